seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Shares a single external hex-to-seven-segment decoder across all digits: drives the decoder's 4-bit nibble input and registers the decoder's active-low 8-bit pattern onto the shared cathode bus.
- Inserts a blanking gap between digits to prevent ghosting.
- Double-buffers the displayed value; updates are accepted only at frame boundaries through a req/ack handshake.

Parameters:
- NUM_DIGITS, 8: digits scanned; legal range 2..8.
- BLANK_CYCLES, 16: clocks per digit with all anodes off; must be >= 1.
- ON_CYCLES, 100000: clocks per digit with the anode driven; must be >= 1.
- LZ_SUPPRESS, 1: 1 = blank leading zeros; 0 = show all enabled digits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_req  in  1  requester holds high until load_ack to update display contents.
- value  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is least significant / rightmost.
- dp_mask  in  NUM_DIGITS  1 = decimal point lit on digit i.
- en_mask  in  NUM_DIGITS  1 = digit i participates in the display.
- load_ack  out  1  one-cycle pulse; shadow registers captured on this edge.
- bcd  out  4  registered nibble to the external decoder.
- seven  in  8  active-low pattern returned by the decoder; bit7 is ignored.
- seg  out  8  active-low cathodes; bit7 = DP, bits6..0 = g..a.
- an  out  NUM_DIGITS  active-low anodes, one-hot-low or all high.
- frame_tick  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async assert, sync release):
  - an = all 1; seg = 8'hFF; bcd = 0; load_ack = 0; frame_tick = 0.
  - idx = 0; cnt = 0; state = BLANK.
  - Shadow value, dp and en = 0, so the display stays dark until the first load.
  - Reset asserted mid-scan or mid-handshake returns to this state immediately; any pending request must be re-issued.
- Two-state FSM per digit, driven by cnt:
  - BLANK lasts BLANK_CYCLES clocks.
  - SHOW lasts ON_CYCLES clocks.
  - Digit period = BLANK_CYCLES + ON_CYCLES.
  - Frame = NUM_DIGITS digit periods.
- Transitions:
  - BLANK -> SHOW when cnt == BLANK_CYCLES-1.
  - SHOW -> BLANK when cnt == ON_CYCLES-1.
  - cnt clears on every transition.
- On the edge entering BLANK:
  - idx advances; it wraps NUM_DIGITS-1 -> 0.
  - bcd <= shadow nibble[new idx].
  - an <= all 1; seg <= 8'hFF.
  - The decoder path therefore has at least one full BLANK cycle to settle.
- On the edge entering SHOW:
  - seg <= {~dp[idx], seven[6:0]}.
  - an[idx] <= 0 if the digit is visible; all other an bits stay 1.
  - If the digit is not visible: an stays all 1 and seg = 8'hFF.
  - Both outputs hold for the whole SHOW period.
- Visible digit: en[idx] = 1 AND not suppressed.
  - With LZ_SUPPRESS = 1, digit i > 0 is suppressed when nibble i and every enabled nibble j > i are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit's DP is also dark.
- Frame wrap = the SHOW -> BLANK edge with idx == NUM_DIGITS-1. On this edge:
  - frame_tick = 1 for one cycle.
  - If load_req == 1: value, dp_mask and en_mask are captured into shadow, and load_ack = 1 for one cycle on the same edge. bcd for digit 0 uses the new shadow.
- Handshake rules:
  - load_req dropping before a wrap means no capture.
  - load_req still high after load_ack triggers another capture at the next wrap; the requester must drop it on seeing load_ack.
  - Inputs are sampled only at the wrap edge; changes at other times have no effect.
- an and seg are never both active during BLANK. No two an bits are ever low at once.

Test Plan:
- Config NUM_DIGITS=4, BLANK_CYCLES=2, ON_CYCLES=4, LZ_SUPPRESS=0.
  - Reset, no load -> an = 4'hF and seg = 8'hFF for 3 full frames (72 clocks); frame_tick every 24 clocks.
- Same config: hold load_req with value=16'h12A0, en=4'hF, dp=4'b0010 -> load_ack single pulse coincident with frame_tick.
  - Next frame, with a reference decoder attached: an sequence 1110, 1101, 1011, 0111.
  - seg = 8'hC0, 8'h08, 8'hA4, 8'hF9 (digits 0, A, 2, 1; DP lit on digit 1 only), each held 4 clocks.
  - 2 blank clocks between digits with an = 4'hF and seg = 8'hFF.
- Same config with LZ_SUPPRESS=1: load value=16'h0050, en=4'hF -> digits 3 and 2 dark; digits 1 and 0 show 5, 0.
  - Load value=16'h0000 -> only digit 0 shows 0.
- Pulse load_req for 3 cycles mid-frame -> no load_ack, display unchanged.
  - Hold load_req across two wraps -> two load_ack pulses, 24 clocks apart.
- Assert rst_n=0 during SHOW of digit 2 -> an = 4'hF, seg = 8'hFF, bcd = 0 asynchronously.
  - After release, display is dark until a new load.
- en_mask=4'b0101 -> digits 1 and 3 keep an high for their slots; timing and frame_tick period unchanged.
- Checker throughout: at most one an bit low at any time.

Source files
------------

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One external hex decoder is shared by all digits: bcd selects the nibble,
// the returned pattern is latched onto seg when the digit's SHOW window opens.
// Each digit gets a BLANK window (all anodes off) before SHOW to avoid ghosting.
// Display contents live in shadow registers that only change at a frame wrap.
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 16,
    parameter int ON_CYCLES    = 100000,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_req,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   en_mask,
    output logic                    load_ack,
    output logic [3:0]              bcd,
    input  logic [7:0]              seven,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int MAXC = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [CW-1:0]                  r_cnt;
    logic [IW-1:0]                  r_idx;
    logic [IW-1:0]                  w_idx_nxt;
    logic [NUM_DIGITS-1:0][3:0]     r_val;
    logic [NUM_DIGITS-1:0]          r_dp;
    logic [NUM_DIGITS-1:0]          r_en;
    logic [3:0]                     r_bcd;
    logic [7:0]                     r_seg;
    logic [NUM_DIGITS-1:0]          r_an;
    logic                           r_load_ack;
    logic                           r_frame_tick;

    logic                           w_to_show;
    logic                           w_to_blank;
    logic                           w_wrap;
    logic                           w_capture;
    logic [NUM_DIGITS-1:0]          w_vis;
    logic                           w_zero_above;
    logic                           w_sup;
    logic                           w_cur_vis;
    logic [NUM_DIGITS-1:0]          w_an_show;
    logic [7:0]                     w_seg_show;

    assign load_ack   = r_load_ack;
    assign bcd        = r_bcd;
    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

    // State register for the per-digit BLANK/SHOW sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_BLANK;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode: each window ends when cnt reaches its length minus one
    always_comb begin
        w_state_nxt = r_state;
        w_to_show   = 1'b0;
        w_to_blank  = 1'b0;
        case (r_state)
            S_BLANK: if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
                w_state_nxt = S_SHOW;
                w_to_show   = 1'b1;
            end
            S_SHOW: if (r_cnt == CW'(ON_CYCLES - 1)) begin
                w_state_nxt = S_BLANK;
                w_to_blank  = 1'b1;
            end
            default: w_state_nxt = S_BLANK;
        endcase
    end

    assign w_wrap    = w_to_blank && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_capture = w_wrap && load_req;
    assign w_idx_nxt = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;

    // Visibility: walk from the top digit down, tracking whether every enabled
    // digit above is zero; digit 0 is always eligible so "0" is never blank
    always_comb begin
        w_vis        = '0;
        w_zero_above = 1'b1;
        w_sup        = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_sup        = (LZ_SUPPRESS != 0) && (i != 0) && (r_val[i] == 4'h0) && w_zero_above;
            w_vis[i]     = r_en[i] && !w_sup;
            w_zero_above = w_zero_above && (!r_en[i] || (r_val[i] == 4'h0));
        end
    end

    assign w_cur_vis = w_vis[r_idx];
    assign w_an_show = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);
    // Decoder bit 7 is masked off so the DP always comes from the shadow mask
    assign w_seg_show = {~r_dp[r_idx], 7'h00} | (seven & 8'h7F);

    // Window counter: restarts on every BLANK/SHOW transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_cnt <= '0;
        else if (w_to_show || w_to_blank) r_cnt <= '0;
        else                             r_cnt <= r_cnt + 1'b1;
    end

    // Shadow registers and handshake: sampled only on the frame-wrap edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val        <= '0;
            r_dp         <= '0;
            r_en         <= '0;
            r_load_ack   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_load_ack   <= w_capture;
            r_frame_tick <= w_wrap;
            if (w_capture) begin
                r_val <= value;
                r_dp  <= dp_mask;
                r_en  <= en_mask;
            end
        end
    end

    // Digit outputs: blank and preload the next nibble on entering BLANK,
    // latch the settled decoder pattern and the anode on entering SHOW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_bcd <= 4'h0;
            r_an  <= '1;
            r_seg <= 8'hFF;
        end else if (w_to_blank) begin
            r_idx <= w_idx_nxt;
            r_bcd <= w_capture ? value[3:0] : r_val[w_idx_nxt];
            r_an  <= '1;
            r_seg <= 8'hFF;
        end else if (w_to_show) begin
            if (w_cur_vis) begin
                r_an  <= w_an_show;
                r_seg <= w_seg_show;
            end else begin
                r_an  <= '1;
                r_seg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (leading-zero blanking off / on)
// share stimulus; expected per-digit slots are queued each frame from a
// reference model of the shadow contents and popped as each SHOW window opens.
module tb_seven_seg_scan;

    localparam int N   = 4;
    localparam int B   = 2;
    localparam int O   = 4;
    localparam int DP_ = B + O;
    localparam int PER = DP_ * N;

    typedef struct packed {
        logic [3:0] an0;
        logic [7:0] seg0;
        logic [3:0] an1;
        logic [7:0] seg1;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  en_mask = '0;

    logic       load_ack0, frame_tick0, load_ack1, frame_tick1;
    logic [3:0] bcd0, an0, bcd1, an1;
    logic [7:0] seven0, seg0, seven1, seg1;

    int    n_cmp = 0;
    int    n_err = 0;
    int    k = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_en = '0;
    slot_t sb[$];
    slot_t cur;

    always #5 clk = ~clk;

    // Reference common-anode hex decoder (bit7 high = DP off)
    function automatic logic [7:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 8'hC0; 4'h1: dec = 8'hF9; 4'h2: dec = 8'hA4; 4'h3: dec = 8'hB0;
            4'h4: dec = 8'h99; 4'h5: dec = 8'h92; 4'h6: dec = 8'h82; 4'h7: dec = 8'hF8;
            4'h8: dec = 8'h80; 4'h9: dec = 8'h90; 4'hA: dec = 8'h88; 4'hB: dec = 8'h83;
            4'hC: dec = 8'hC6; 4'hD: dec = 8'hA1; 4'hE: dec = 8'h86; default: dec = 8'h8E;
        endcase
    endfunction

    assign seven0 = dec(bcd0);
    assign seven1 = dec(bcd1);

    seven_seg_scan #(.NUM_DIGITS(N), .BLANK_CYCLES(B), .ON_CYCLES(O), .LZ_SUPPRESS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .value(value), .dp_mask(dp_mask),
        .en_mask(en_mask), .load_ack(load_ack0), .bcd(bcd0), .seven(seven0), .seg(seg0),
        .an(an0), .frame_tick(frame_tick0));

    seven_seg_scan #(.NUM_DIGITS(N), .BLANK_CYCLES(B), .ON_CYCLES(O), .LZ_SUPPRESS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .value(value), .dp_mask(dp_mask),
        .en_mask(en_mask), .load_ack(load_ack1), .bcd(bcd1), .seven(seven1), .seg(seg1),
        .an(an1), .frame_tick(frame_tick1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Digit d lit? Enabled, and with blanking on, nonzero or some enabled digit above nonzero
    function automatic bit vis(input int d, input bit lz);
        bit nz_above;
        nz_above = 1'b0;
        if (!m_en[d]) return 1'b0;
        if (!lz || d == 0) return 1'b1;
        if (m_val[d*4 +: 4] != 4'h0) return 1'b1;
        for (int j = d + 1; j < N; j++)
            if (m_en[j] && m_val[j*4 +: 4] != 4'h0) nz_above = 1'b1;
        return nz_above;
    endfunction

    function automatic slot_t mk_slot(input int d);
        slot_t s;
        logic [7:0] p;
        logic [7:0] lit;
        p   = dec(m_val[d*4 +: 4]);
        lit = {~m_dp[d], p[6:0]};
        s.an0  = vis(d, 1'b0) ? ~(4'b0001 << d) : 4'hF;
        s.seg0 = vis(d, 1'b0) ? lit : 8'hFF;
        s.an1  = vis(d, 1'b1) ? ~(4'b0001 << d) : 4'hF;
        s.seg1 = vis(d, 1'b1) ? lit : 8'hFF;
        return s;
    endfunction

    task automatic push_frame();
        for (int d = 0; d < N; d++) sb.push_back(mk_slot(d));
    endtask

    // One clock: advance the model on the edge, then check all outputs at negedge
    task automatic cyc();
        bit          lr_e;
        logic [15:0] v_e;
        logic [3:0]  dp_e, en_e;
        int          pos, d, s;
        lr_e = load_req; v_e = value; dp_e = dp_mask; en_e = en_mask;
        @(posedge clk);
        k++;
        pos = k % PER;
        if (pos == 0 && lr_e) begin
            m_val = v_e; m_dp = dp_e; m_en = en_e;
        end
        if (pos == 0) push_frame();
        @(negedge clk);
        d = pos / DP_;
        s = pos % DP_;
        chk("tick0", 32'(frame_tick0), 32'(pos == 0));
        chk("tick1", 32'(frame_tick1), 32'(pos == 0));
        chk("ack0", 32'(load_ack0), 32'(pos == 0 && lr_e));
        chk("ack1", 32'(load_ack1), 32'(pos == 0 && lr_e));
        if (s == B - 1) begin
            chk("bcd0", 32'(bcd0), 32'(m_val[d*4 +: 4]));
            chk("bcd1", 32'(bcd1), 32'(m_val[d*4 +: 4]));
        end
        if (s == B) begin
            chk("sb_level", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) cur = sb.pop_front();
        end
        if (s >= B) begin
            chk("an0_show", 32'(an0), 32'(cur.an0));
            chk("seg0_show", 32'(seg0), 32'(cur.seg0));
            chk("an1_show", 32'(an1), 32'(cur.an1));
            chk("seg1_show", 32'(seg1), 32'(cur.seg1));
        end else begin
            chk("an0_blank", 32'(an0), 32'h0F);
            chk("seg0_blank", 32'(seg0), 32'hFF);
            chk("an1_blank", 32'(an1), 32'h0F);
            chk("seg1_blank", 32'(seg1), 32'hFF);
        end
        chk("onehot0", 32'($countones(~an0) <= 1), 32'd1);
        chk("onehot1", 32'($countones(~an1) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic run_to(input int p);
        while ((k % PER) != p) cyc();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an0"}, 32'(an0), 32'h0F);
        chk({tag, "_seg0"}, 32'(seg0), 32'hFF);
        chk({tag, "_bcd0"}, 32'(bcd0), 32'h0);
        chk({tag, "_an1"}, 32'(an1), 32'h0F);
        chk({tag, "_seg1"}, 32'(seg1), 32'hFF);
        chk({tag, "_bcd1"}, 32'(bcd1), 32'h0);
        chk({tag, "_ack"}, 32'({load_ack0, load_ack1}), 32'h0);
        chk({tag, "_tick"}, 32'({frame_tick0, frame_tick1}), 32'h0);
    endtask

    // Assert reset (checked asynchronously), hold across a clock edge, release at negedge
    task automatic do_reset(input bit mid);
        rst_n = 1'b0;
        load_req = 1'b0;
        #1;
        if (mid) check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        k = 0;
        m_val = '0; m_dp = '0; m_en = '0;
        sb.delete();
        push_frame();
    endtask

    // Hold load_req through nwraps frame wraps, then drop it and scramble the data
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                           input int nwraps);
        int w;
        w = 0;
        value = v; dp_mask = dp; en_mask = en; load_req = 1'b1;
        while (w < nwraps) begin
            cyc();
            if ((k % PER) == 0) w++;
        end
        load_req = 1'b0;
        value = ~v; dp_mask = ~dp; en_mask = ~en;
    endtask

    initial begin
        do_reset(1'b0);
        run(3 * PER);                          // dark for three frames, tick every 24

        do_load(16'h12A0, 4'b0010, 4'hF, 1);   // 0, A., 2, 1
        run(PER);

        do_load(16'h0050, 4'b0000, 4'hF, 1);   // blanking instance hides digits 3,2
        run(PER);

        do_load(16'h0000, 4'b0000, 4'hF, 1);   // blanking instance shows only digit 0
        run(PER);

        run_to(5);                             // short mid-frame pulse: ignored
        value = 16'h9876; dp_mask = 4'hF; load_req = 1'b1;
        run(3);
        load_req = 1'b0;
        run(2 * PER);

        do_load(16'hBEEF, 4'b0101, 4'hF, 2);   // two acks, one frame apart
        run(PER);

        do_load(16'h4321, 4'b1000, 4'b0101, 1); // digits 1,3 disabled
        run(PER);

        run_to(2 * DP_ + B);                   // first SHOW cycle of digit 2
        do_reset(1'b1);
        run(2 * PER);                          // dark again until a new load

        do_load(16'h00C7, 4'b0001, 4'hF, 1);
        run(PER);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
